// File: rtl/uart_rx.sv
// uart_rx: oversampling serial receiver.
// Recovers DBIT-data-bit, no-parity frames from the asynchronous rx line using
// the shared 16x baud tick. Each good byte is presented on dout together with a
// one-cycle rx_done_tick. A low stop bit gives a one-cycle frame_err instead,
// and dout keeps its previous value.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | line idle; waiting for rx_s to fall (no tick needed)
//   ST_START | counting 8 ticks to mid start bit; high there is a glitch
//   ST_DATA  | sampling one data bit every 16 ticks, LSB first
//   ST_STOP  | stop bit sampled at s=15; frame resolved at s=SB_TICK-1
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  // The tick counter must reach SB_TICK-1 in the stop state, so it grows
  // beyond 4 bits for 1.5 and 2 stop-bit builds.
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID      = SW'(7);
  localparam logic [SW-1:0] S_LAST     = SW'(15);
  localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
  localparam logic [SW-1:0] S_ONE      = SW'(1);
  localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);
  localparam logic [NW-1:0] N_ONE      = NW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic            rx_meta;
  logic            rx_s;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            stop_q, stop_d;
  logic            stop_bit;
  logic            done_d;
  logic            err_d;

  // Two-flop synchronizer; resets to the idle-high line level so a reset
  // never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Next-state, counter and strobe decode; everything except the idle exit
  // advances only on a baud tick.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    n_d      = n_q;
    b_d      = b_q;
    stop_d   = stop_q;
    stop_bit = stop_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = ST_STOP;
            end else begin
              n_d = n_q + N_ONE;
            end
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end

      ST_STOP: begin
        if (s_tick) begin
          // With one stop bit the sample point and the end of the state fall
          // on the same tick, so the live value bypasses the held copy.
          if (s_q == S_LAST) begin
            stop_d   = rx_s;
            stop_bit = rx_s;
          end
          if (s_q == S_STOP_END) begin
            state_d = ST_IDLE;
            if (stop_bit) begin
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            s_d = s_q + S_ONE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, shift register and the registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      stop_q       <= 1'b1;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      n_q          <= n_d;
      b_q          <= b_d;
      stop_q       <= stop_d;
      rx_done_tick <= done_d;
      frame_err    <= err_d;
      if (done_d) begin
        dout <= b_q;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into a default build and an SB_TICK=32 build.
// The model predicts, per frame, the strobe kind, the tick at which it must
// appear (start + 8 + 16*DBIT + SB_TICK) and the byte; dout must otherwise
// hold the last good byte.
module tb_uart_rx;

  localparam int DBIT = 8;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
    int         tick;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic       rx;
  logic       rx32;
  logic [7:0] dout;
  logic [7:0] dout32;
  logic       done;
  logic       ferr;
  logic       done32;
  logic       ferr32;

  int   vectors;
  int   miscompares;
  int   ticks_seen;
  int   div;
  logic rst_d;
  logic check_en;
  logic [7:0] model_dout;
  exp_t exp_q[$];
  int   done_ticks[$];
  int   n_done;
  int   n_err;
  int   n32;
  int   e32;
  int   tick32;
  logic [7:0] d32;
  int   k32;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx),
    .dout(dout), .rx_done_tick(done), .frame_err(ferr)
  );

  uart_rx #(.DBIT(8), .SB_TICK(32)) dut32 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx32),
    .dout(dout32), .rx_done_tick(done32), .frame_err(ferr32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-cycle baud tick every 16 clocks, changed on the falling edge.
  initial begin
    s_tick = 1'b0;
    div    = 0;
    forever begin
      @(negedge clk);
      div    = (div + 1) % 16;
      s_tick = (div == 0);
    end
  end

  // Tick count and reset history as seen by the DUT at each rising edge.
  initial begin
    ticks_seen = 0;
    rst_d      = 1'b1;
    forever begin
      @(posedge clk);
      if (s_tick) ticks_seen = ticks_seen + 1;
      rst_d = reset;
    end
  end

  // Per-cycle compare of the default build against the model.
  initial begin
    exp_t e;
    model_dout = 8'h00;
    n_done     = 0;
    n_err      = 0;
    forever begin
      @(negedge clk);
      if (rst_d) begin
        model_dout = 8'h00;
        exp_q.delete();
      end else if (check_en) begin
        vectors++;
        if (done && ferr) begin
          miscompares++;
          $display("FAIL strobe_overlap: done=%0b ferr=%0b, required not both", done, ferr);
        end
        if (done || ferr) begin
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_strobe: done=%0b ferr=%0b at tick %0d, required none",
                     done, ferr, ticks_seen);
          end else begin
            e = exp_q.pop_front();
            if (e.is_err != ferr || ticks_seen != e.tick) begin
              miscompares++;
              $display("FAIL strobe: ferr=%0b tick=%0d, required ferr=%0b tick=%0d",
                       ferr, ticks_seen, e.is_err, e.tick);
            end
            if (done) begin
              if (dout !== e.data) begin
                miscompares++;
                $display("FAIL done_dout: got %02h required %02h", dout, e.data);
              end
              model_dout = e.data;
              done_ticks.push_back(ticks_seen);
              n_done++;
            end else begin
              n_err++;
            end
          end
        end else if (exp_q.size() > 0 && ticks_seen > exp_q[0].tick) begin
          miscompares++;
          $display("FAIL missing_strobe: none by tick %0d, required at tick %0d",
                   ticks_seen, exp_q[0].tick);
          void'(exp_q.pop_front());
        end
        if (!done && dout !== model_dout) begin
          miscompares++;
          $display("FAIL dout_hold: got %02h required %02h", dout, model_dout);
        end
      end
    end
  end

  // Strobe monitor for the two-stop-bit build.
  initial begin
    n32    = 0;
    e32    = 0;
    tick32 = 0;
    d32    = 8'h00;
    forever begin
      @(negedge clk);
      if (done32 || ferr32) begin
        n32++;
        if (ferr32) e32++;
        tick32 = ticks_seen;
        d32    = dout32;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (s_tick !== 1'b1);
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx32 = v;
    else     rx   = v;
  endtask

  // Serialises one frame. abort_bit >= 0 stops halfway through that data bit
  // and registers no expectation.
  task automatic send_frame(input bit sel, input logic [7:0] data, input logic stop_val,
                            input int stop_ticks, input int abort_bit);
    exp_t e;
    int   k;
    k = ticks_seen;
    if (abort_bit < 0 && !sel) begin
      e.is_err = !stop_val;
      e.data   = data;
      e.tick   = k + 8 + 16 * DBIT + 16;
      exp_q.push_back(e);
    end
    drive(sel, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < DBIT; i++) begin
      drive(sel, data[i]);
      if (i == abort_bit) begin
        wait_ticks(8);
        return;
      end
      wait_ticks(16);
    end
    drive(sel, stop_val);
    wait_ticks(stop_ticks);
    drive(sel, 1'b1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    check_en    = 1'b0;
    reset       = 1'b1;
    rx          = 1'b1;
    rx32        = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_dout", 32'(dout), 32'h00);
    check("reset_done", 32'(done), 32'h0);
    check("reset_ferr", 32'(ferr), 32'h0);
    reset    = 1'b0;
    check_en = 1'b1;
    wait_ticks(2);

    send_frame(0, 8'hA5, 1'b1, 16, -1);
    wait_ticks(4);
    check("a5_done_count", 32'(n_done), 32'd1);
    check("a5_dout", 32'(dout), 32'hA5);
    check("a5_ferr_count", 32'(n_err), 32'd0);

    send_frame(0, 8'h00, 1'b1, 16, -1);
    send_frame(0, 8'hFF, 1'b1, 16, -1);
    wait_ticks(4);
    check("b2b_done_count", 32'(n_done), 32'd3);
    if (done_ticks.size() >= 3)
      check("b2b_spacing", 32'(done_ticks[2] - done_ticks[1]), 32'd160);
    check("ff_dout", 32'(dout), 32'hFF);

    drive(0, 1'b0);
    wait_ticks(4);
    drive(0, 1'b1);
    wait_ticks(16);
    check("glitch_no_strobe", 32'(n_done + n_err), 32'd3);
    check("glitch_dout", 32'(dout), 32'hFF);
    send_frame(0, 8'h3C, 1'b1, 16, -1);
    wait_ticks(4);
    check("3c_dout", 32'(dout), 32'h3C);

    send_frame(0, 8'h5A, 1'b1, 16, -1);
    send_frame(0, 8'h81, 1'b0, 9, -1);
    wait_ticks(16);
    check("ferr_count", 32'(n_err), 32'd1);
    check("ferr_no_done", 32'(n_done), 32'd5);
    check("ferr_dout", 32'(dout), 32'h5A);

    send_frame(0, 8'hC3, 1'b1, 16, 4);
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ferr", 32'(ferr), 32'h0);
    wait_ticks(32);
    check("abort_no_strobe", 32'(n_done + n_err), 32'd6);
    send_frame(0, 8'h99, 1'b1, 16, -1);
    wait_ticks(4);
    check("99_dout", 32'(dout), 32'h99);
    check("99_done_count", 32'(n_done), 32'd6);

    k32 = ticks_seen;
    send_frame(1, 8'h7E, 1'b1, 32, -1);
    wait_ticks(4);
    check("sb32_count", 32'(n32), 32'd1);
    check("sb32_timing", 32'(tick32 - k32), 32'd168);
    check("sb32_dout", 32'(d32), 32'h7E);
    check("sb32_ferr", 32'(e32), 32'd0);

    wait_ticks(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
